// File: rtl/psram_resp_pkg.sv
// Shared types and constants for the QSPI PSRAM responder.
package psram_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0]  PSRAM_CMD_QREAD  = 8'hEB;
  localparam logic [7:0]  PSRAM_CMD_QWRITE = 8'h38;
  localparam int unsigned ADDR_W           = 24;
  localparam int unsigned CMD_BITS         = 8;
  localparam int unsigned ADDR_NIBBLES     = 6;

endpackage

// File: rtl/psram_resp_mem.sv
// Single-port byte RAM with registered read; kept separate so it can be swapped for a macro.
module psram_resp_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_resp.sv
// QSPI PSRAM device-side responder: oversamples sck/ce/io on clk_i, decodes
// quad read/write frames and serves them from an internal byte array.
module psram_resp
  import psram_resp_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned WAIT_CYC  = 6
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [3:0] psram_io_in_i,
  output logic [3:0] psram_io_out_o,
  output logic [3:0] psram_io_en_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam logic [3:0]  CMD_LAST  = 4'(CMD_BITS - 1);
  localparam logic [3:0]  ADDR_LAST = 4'(ADDR_NIBBLES - 1);
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

  logic          sck_q, sck_qq, ce_q, ce_qq;
  logic [3:0]    io_q;
  logic          rise, fall;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d, cmd_next;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_pend_q, wr_pend_d;
  logic [3:0]    wr_hi_q, wr_hi_d;
  logic          rd_lo_q, rd_lo_d;
  logic [3:0]    io_out_q, io_out_d;
  logic [3:0]    io_en_q, io_en_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic [7:0]    mem_wdata, mem_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sck_q  <= 1'b0;
      sck_qq <= 1'b0;
      ce_q   <= 1'b0;
      ce_qq  <= 1'b0;
      io_q   <= '0;
    end else begin
      sck_q  <= psram_sck_i;
      sck_qq <= sck_q;
      ce_q   <= psram_ce_i;
      ce_qq  <= ce_q;
      io_q   <= psram_io_in_i;
    end
  end

  assign rise = sck_q & ~sck_qq;
  assign fall = ~sck_q & sck_qq;

  psram_resp_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (addr_q),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wr_pend_d = wr_pend_q;
    wr_hi_d   = wr_hi_q;
    rd_lo_d   = rd_lo_q;
    io_out_d  = io_out_q;
    io_en_d   = io_en_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {wr_hi_q, io_q};
    cmd_next  = {cmd_q[6:0], io_q[0]};

    // CE high overrides every state; a half-received write byte is dropped here.
    if (ce_q) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      wr_pend_d = 1'b0;
      rd_lo_d   = 1'b0;
      io_out_d  = '0;
      io_en_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ce_qq) begin
            state_d   = ST_CMD;
            cnt_d     = '0;
            wr_pend_d = 1'b0;
            rd_lo_d   = 1'b0;
          end
        end
        ST_CMD: begin
          if (rise) begin
            cmd_d = cmd_next;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CMD_LAST) begin
              cnt_d = '0;
              if (cmd_next == PSRAM_CMD_QREAD || cmd_next == PSRAM_CMD_QWRITE) begin
                state_d = ST_ADDR;
              end else begin
                state_d = ST_IGNORE;
                err_d   = 1'b1;
              end
            end
          end
        end
        ST_ADDR: begin
          if (rise) begin
            addr_d = {addr_q[AW-5:0], io_q};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == ADDR_LAST) begin
              cnt_d = '0;
              if (cmd_q == PSRAM_CMD_QWRITE) state_d = ST_WDATA;
              else if (WAIT_CYC == 0)        state_d = ST_RDATA;
              else                           state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WAIT_LAST) begin
              cnt_d   = '0;
              state_d = ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          // Address bumps after the low nibble so the next byte is read well before the next fall.
          if (fall) begin
            io_en_d  = '1;
            io_out_d = rd_lo_q ? mem_rdata[3:0] : mem_rdata[7:4];
            rd_lo_d  = ~rd_lo_q;
            if (rd_lo_q) addr_d = addr_q + 1'b1;
          end
        end
        ST_WDATA: begin
          if (rise) begin
            if (!wr_pend_q) begin
              wr_hi_d   = io_q;
              wr_pend_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              wr_pend_d = 1'b0;
              addr_d    = addr_q + 1'b1;
            end
          end
        end
        ST_IGNORE: begin
          io_en_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wr_pend_q <= 1'b0;
      wr_hi_q   <= '0;
      rd_lo_q   <= 1'b0;
      io_out_q  <= '0;
      io_en_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wr_pend_q <= wr_pend_d;
      wr_hi_q   <= wr_hi_d;
      rd_lo_q   <= rd_lo_d;
      io_out_q  <= io_out_d;
      io_en_q   <= io_en_d;
      err_q     <= err_d;
    end
  end

  assign psram_io_out_o = io_out_q;
  assign psram_io_en_o  = io_en_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign err_o          = err_q;

endmodule
